// File: rtl/ofmap_streamer.sv
// ofmap_streamer: snapshots the pooled feature frame on start, then streams
// it out in raster order over a valid/ready port while the accelerator is
// free to begin computing the next frame.
//
// Handshake: a beat transfers on a rising edge where m_valid && m_ready.
// While m_valid is high and m_ready is low, m_data, m_row_last and
// m_frame_last hold their values. m_valid only falls after the frame_last
// beat transfers, or on reset.
module ofmap_streamer #(
  parameter int OFMAP_HEIGHT = 64,
  parameter int OFMAP_WIDTH  = 64,
  parameter int DATA_WIDTH   = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [DATA_WIDTH-1:0] feature_in [0:OFMAP_HEIGHT-1][0:OFMAP_WIDTH-1],
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_row_last,
  output logic                  m_frame_last,
  output logic                  busy,
  output logic                  done,
  output logic                  start_dropped,
  output logic                  state_dbg
);

  localparam int RW = (OFMAP_HEIGHT > 1) ? $clog2(OFMAP_HEIGHT) : 1;
  localparam int CW = (OFMAP_WIDTH > 1) ? $clog2(OFMAP_WIDTH) : 1;
  localparam logic [RW-1:0] ROW_MAX = RW'(OFMAP_HEIGHT - 1);
  localparam logic [CW-1:0] COL_MAX = CW'(OFMAP_WIDTH - 1);

  typedef enum logic {
    S_IDLE   = 1'b0,
    S_STREAM = 1'b1
  } state_t;

  state_t                state_q;
  state_t                state_d;
  logic [RW-1:0]         row_q;
  logic [CW-1:0]         col_q;
  logic [DATA_WIDTH-1:0] frame_buf [0:OFMAP_HEIGHT-1][0:OFMAP_WIDTH-1];
  logic                  done_q;
  logic                  dropped_q;

  logic                  accept;
  logic                  drop_d;
  logic                  done_d;
  logic                  hs;
  logic                  at_row_end;
  logic                  at_frame_end;

  assign hs           = (state_q == S_STREAM) && m_ready;
  assign at_row_end   = (col_q == COL_MAX);
  assign at_frame_end = at_row_end && (row_q == ROW_MAX);

  // Next-state and one-cycle event decode.
  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    drop_d  = 1'b0;
    done_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          accept  = 1'b1;
          state_d = S_STREAM;
        end
      end
      S_STREAM: begin
        if (start) drop_d = 1'b1;
        if (hs && at_frame_end) begin
          done_d  = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State register; reset abandons any frame in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Raster position: restarts on an accepted start, steps on each handshake.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      row_q <= '0;
      col_q <= '0;
    end else if (accept) begin
      row_q <= '0;
      col_q <= '0;
    end else if (hs) begin
      if (at_row_end) begin
        col_q <= '0;
        row_q <= (row_q == ROW_MAX) ? '0 : row_q + RW'(1);
      end else begin
        col_q <= col_q + CW'(1);
      end
    end
  end

  // Frame snapshot; contents are only meaningful after an accepted start.
  always_ff @(posedge clk) begin
    if (accept) frame_buf <= feature_in;
  end

  // Registered single-cycle status pulses.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      done_q    <= 1'b0;
      dropped_q <= 1'b0;
    end else begin
      done_q    <= done_d;
      dropped_q <= drop_d;
    end
  end

  assign m_valid       = (state_q == S_STREAM);
  assign busy          = (state_q == S_STREAM);
  assign m_data        = m_valid ? frame_buf[row_q][col_q] : '0;
  assign m_row_last    = m_valid && at_row_end;
  assign m_frame_last  = m_valid && at_frame_end;
  assign done          = done_q;
  assign start_dropped = dropped_q;
  assign state_dbg     = state_q;

endmodule
